// File: rtl/lcd_arb_pkg.sv
// Shared types and constants for the LCD write arbiter.
// Holds the FSM encoding, requester indices and default watchdog limit.
package lcd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        WAIT_BUSY  = 2'd2,
        WAIT_READY = 2'd3
    } arbState_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_MSG = 1'b1;

    localparam logic [19:0] DEFAULT_TIMEOUT_CYCLES = 20'd1000000;

    // Round-robin between two requesters; lastGrant loses a tie.
    function automatic logic pickWinner(
        input logic req0,
        input logic req1,
        input logic lastGrant
    );
        logic winner;
        if (req0 && req1) begin
            winner = ~lastGrant;
        end else if (req0) begin
            winner = REQ_CPU;
        end else begin
            winner = REQ_MSG;
        end
        return winner;
    endfunction

endpackage

// File: rtl/lcd_arb_watchdog.sv
// Cycle counter that flags when a driver wait exceeds its limit.
// Clears whenever the arbiter is not waiting on the driver.
import lcd_arb_pkg::*;

module lcd_arb_watchdog #(
    parameter logic [19:0] LIMIT = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic iRun,
    output logic oExpired
);

    logic [19:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 20'd0;
        end else if (iRun) begin
            count <= count + 20'd1;
        end else begin
            count <= 20'd0;
        end
    end

    assign oExpired = iRun && (count == (LIMIT - 20'd1));

endmodule

// File: rtl/lcd_write_arbiter.sv
// Two-requester round-robin arbiter in front of the LCD character driver.
// Optional watchdog enabled by defining LCD_WRITE_ARB_TIMEOUT_EN.
import lcd_arb_pkg::*;

module lcd_write_arbiter #(
    parameter logic [19:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iInitialized,
    input  logic       iReady,
    input  logic       iReq0,
    input  logic [7:0] iData0,
    input  logic       iReq1,
    input  logic [7:0] iData1,
    output logic       oAck0,
    output logic       oAck1,
    output logic       oWrite,
    output logic [7:0] oData,
    output logic       oBusy,
    output logic       oGrant,
    output logic       oTimeout
);

    arbState_t  state;
    arbState_t  nextState;
    logic       nextWrite;
    logic [7:0] nextData;
    logic       nextGrant;
    logic       nextAck0;
    logic       nextAck1;
    logic       nextBusy;
    logic       waiting;
    logic       expired;

    assign waiting = (state == WAIT_BUSY) || (state == WAIT_READY);

`ifdef LCD_WRITE_ARB_TIMEOUT_EN
    logic timeoutHit;
    logic timeoutQ;

    lcd_arb_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) uWatchdog (
        .clk     (Clock),
        .rst     (Reset),
        .iRun    (waiting),
        .oExpired(expired)
    );

    assign timeoutHit = expired && iInitialized &&
                        ((state == WAIT_BUSY) ||
                         ((state == WAIT_READY) && !iReady));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            timeoutQ <= 1'b0;
        end else if (timeoutHit) begin
            timeoutQ <= 1'b1;
        end
    end

    assign oTimeout = timeoutQ;
`else
    logic unusedTimeoutCfg;

    assign unusedTimeoutCfg = ^{TIMEOUT_CYCLES, waiting};
    assign expired          = 1'b0;
    assign oTimeout         = 1'b0;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            oWrite <= 1'b0;
            oData  <= 8'h00;
            oAck0  <= 1'b0;
            oAck1  <= 1'b0;
            oGrant <= REQ_MSG;
            oBusy  <= 1'b0;
        end else begin
            state  <= nextState;
            oWrite <= nextWrite;
            oData  <= nextData;
            oAck0  <= nextAck0;
            oAck1  <= nextAck1;
            oGrant <= nextGrant;
            oBusy  <= nextBusy;
        end
    end

    always_comb begin
        nextState = state;
        nextWrite = 1'b0;
        nextData  = oData;
        nextGrant = oGrant;
        nextAck0  = 1'b0;
        nextAck1  = 1'b0;

        unique case (state)
            IDLE: begin
                // The ack cycle itself never grants, so a requester
                // still holding its line cannot be served twice.
                if (iInitialized && iReady && (iReq0 || iReq1) &&
                    !oAck0 && !oAck1) begin
                    nextGrant = pickWinner(iReq0, iReq1, oGrant);
                    nextData  = (nextGrant == REQ_MSG) ? iData1 : iData0;
                    nextWrite = 1'b1;
                    nextState = ISSUE;
                end
            end
            ISSUE: begin
                nextState = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (expired) begin
                    nextAck0  = (oGrant == REQ_CPU);
                    nextAck1  = (oGrant == REQ_MSG);
                    nextState = IDLE;
                end else if (!iReady) begin
                    nextState = WAIT_READY;
                end
            end
            WAIT_READY: begin
                if (iReady || expired) begin
                    nextAck0  = (oGrant == REQ_CPU);
                    nextAck1  = (oGrant == REQ_MSG);
                    nextState = IDLE;
                end
            end
        endcase

        // Losing the driver mid-write abandons the transfer silently.
        if ((state != IDLE) && !iInitialized) begin
            nextState = IDLE;
            nextWrite = 1'b0;
            nextAck0  = 1'b0;
            nextAck1  = 1'b0;
        end

        nextBusy = (nextState != IDLE);
    end

endmodule
